// File: rtl/datamem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port 32-word datamem.
// Optional alignment/range check enabled by defining DATAMEM_ARB_ERR_EN.
module datamem_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] writeData,
    output logic              memWrite,
    output logic              memRead,
    input  logic [DATA_W-1:0] readData,
    output logic              err
);
    // Top bit of the word index; anything above it is out of range.
    localparam int IDX_HI = $clog2(MEM_WORDS) + 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state;
    logic              last;
    logic              sel;
    logic              err_q;
    logic              win;
    logic              win_we;
    logic              bad;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    // Under contention the port that did not go last wins.
    always_comb begin
        win       = (req == 2'b10) || ((req == 2'b11) && !last);
        win_we    = win ? we[1] : we[0];
        win_addr  = win ? addr1 : addr0;
        win_wdata = win ? wdata1 : wdata0;
    end

`ifdef DATAMEM_ARB_ERR_EN
    assign bad = (win_addr[1:0] != 2'b00) || (win_addr[ADDR_W-1:IDX_HI+1] != '0);
`else
    assign bad = 1'b0;
`endif

    // address/writeData double as the latched request, so datamem controls
    // come straight from flops and never from the request inputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            last      <= 1'b1;
            sel       <= 1'b0;
            err_q     <= 1'b0;
            ack       <= 2'b00;
            rdata     <= '0;
            busy      <= 1'b0;
            address   <= '0;
            writeData <= '0;
            memWrite  <= 1'b0;
            memRead   <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        sel       <= win;
                        err_q     <= bad;
                        address   <= win_addr;
                        writeData <= win_wdata;
                        memWrite  <= win_we && !bad;
                        memRead   <= !win_we && !bad;
                        busy      <= 1'b1;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (memRead)
                        rdata <= readData;
                    memWrite  <= 1'b0;
                    memRead   <= 1'b0;
                    address   <= '0;
                    writeData <= '0;
                    ack       <= sel ? 2'b10 : 2'b01;
                    err       <= err_q;
                    state     <= DONE;
                end
                DONE: begin
                    ack   <= 2'b00;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    last  <= sel;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_datamem_arbiter.sv
// Randomized bench for datamem_arbiter against a transaction-level model
// (pending requests, last winner, reference memory image).
module tb_datamem_arbiter;
    logic        clock;
    logic        reset;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [1:0]  ack;
    logic [31:0] rdata;
    logic        busy;
    logic [31:0] address, writeData;
    logic        memWrite, memRead;
    logic [31:0] readData;
    logic        err;

    datamem_arbiter dut (
        .clock(clock), .reset(reset), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack(ack), .rdata(rdata), .busy(busy), .address(address),
        .writeData(writeData), .memWrite(memWrite), .memRead(memRead),
        .readData(readData), .err(err)
    );

`ifdef DATAMEM_ARB_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    // datamem stand-in: combinational read, write on the rising edge
    logic [31:0] mem [32];
    always @(posedge clock) if (memWrite) mem[address[6:2]] <= writeData;
    assign readData = mem[address[6:2]];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] ref_mem [32];
    logic [1:0]  pend;
    logic        p_we    [2];
    logic [31:0] p_addr  [2];
    logic [31:0] p_wdata [2];
    bit          last_m;
    logic [31:0] exp_rdata;
    logic [31:0] scr_xor;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, expv);
        end
    endtask

    function automatic bit is_bad(input logic [31:0] a);
        return ERR_EN && ((a[1:0] != 2'b00) || (a[31:7] != 25'b0));
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = {25'b0, 5'($urandom_range(0, 31)), 2'b00};
        case ($urandom_range(0, 7))
            0: a[1:0] = 2'($urandom_range(1, 3));
            1: a[31:7] = 25'($urandom_range(1, 32'h1FF_FFFF));
            default: ;
        endcase
        return a;
    endfunction

    task automatic drive();
        req    = pend;
        we     = {p_we[1], p_we[0]};
        addr0  = p_addr[0];
        addr1  = p_addr[1];
        wdata0 = p_wdata[0];
        wdata1 = p_wdata[1];
    endtask

    task automatic post(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
        pend[p]    = 1'b1;
        p_we[p]    = w;
        p_addr[p]  = a;
        p_wdata[p] = d;
    endtask

    // Entered at a falling edge in IDLE with requests driven; leaves at the
    // falling edge of the following IDLE cycle.
    task automatic round(input bit keep);
        int          w;
        bit          bad;
        logic        wr;
        logic [31:0] a, d;
        logic [4:0]  idx;
        if (pend == 2'b00) begin
            @(posedge clock);
            @(negedge clock);
            chk("idle_busy", busy, 0);
            chk("idle_mem", {memWrite, memRead}, 0);
            return;
        end
        if (pend == 2'b01) w = 0;
        else if (pend == 2'b10) w = 1;
        else w = last_m ? 0 : 1;
        a = p_addr[w]; d = p_wdata[w]; wr = p_we[w];
        bad = is_bad(a);
        idx = a[6:2];
        @(posedge clock);
        #1;
        // winner's inputs wander after sampling; the latched copy must be used
        if (w == 0) begin addr0 = a ^ scr_xor; wdata0 = ~d; end
        else begin addr1 = a ^ scr_xor; wdata1 = ~d; end
        we[w] = ~wr;
        @(negedge clock);
        chk("acc_busy", busy, 1);
        chk("acc_ack", ack, 0);
        chk("acc_memWrite", memWrite, wr && !bad);
        chk("acc_memRead", memRead, !wr && !bad);
        if (!bad) begin
            chk("acc_address", address, a);
            if (wr) begin
                chk("acc_writeData", writeData, d);
                ref_mem[idx] = d;
            end else begin
                exp_rdata = ref_mem[idx];
            end
        end
        @(negedge clock);
        chk("done_ack", ack, (w == 0) ? 2'b01 : 2'b10);
        chk("done_err", err, bad);
        chk("done_mem", {memWrite, memRead}, 0);
        chk("done_busy", busy, 1);
        chk("done_rdata", rdata, exp_rdata);
        last_m = (w == 1);
        if (!keep) pend[w] = 1'b0;
        drive();
        @(negedge clock);
        chk("idle_busy", busy, 0);
        chk("idle_ack", ack, 0);
        chk("idle_err", err, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pend = 2'b00;
        drive();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        last_m = 1'b1;
        exp_rdata = '0;
    endtask

    initial begin
        reset = 1'b1;
        pend = 2'b00;
        for (int p = 0; p < 2; p++) begin p_we[p] = 0; p_addr[p] = 0; p_wdata[p] = 0; end
        scr_xor = '0;
        drive();
        @(negedge clock);
        @(negedge clock);
        chk("rst_ack", ack, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_address", address, 0);
        chk("rst_writeData", writeData, 0);
        chk("rst_mem", {memWrite, memRead}, 0);
        chk("rst_err", err, 0);
        reset = 1'b0;
        last_m = 1'b1;
        exp_rdata = '0;

        // fill datamem with known contents through the arbiter
        for (int i = 0; i < 32; i++) begin
            post(1, 1'b1, 32'(i * 4), $urandom);
            drive();
            round(0);
        end

        // port0 write then port1 read back
        do_reset();
        scr_xor = $urandom;
        post(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        drive();
        round(0);
        post(1, 1'b0, 32'h0000_0010, 32'h0);
        drive();
        round(0);
        chk("dir_rdata", rdata, 32'hDEAD_BEEF);

        // contention from reset: strict alternation starting with port 0
        do_reset();
        post(0, 1'b1, 32'h0000_0040, $urandom);
        post(1, 1'b1, 32'h0000_0044, $urandom);
        drive();
        for (int i = 0; i < 4; i++) round(1);
        pend = 2'b00;
        drive();

        // reset in the middle of a write to word 8
        post(0, 1'b1, 32'h0000_0020, 32'h1234_5678);
        drive();
        @(posedge clock);
        @(negedge clock);
        chk("rstacc_pre_memWrite", memWrite, 1);
        reset = 1'b1;
        pend = 2'b00;
        drive();
        #1;
        chk("rstacc_memWrite", memWrite, 0);
        chk("rstacc_outs", {ack, busy, memRead, err}, 0);
        chk("rstacc_address", address, 0);
        chk("rstacc_rdata", rdata, 0);
        @(negedge clock);
        chk("rstacc_ack", ack, 0);
        reset = 1'b0;
        last_m = 1'b1;
        exp_rdata = '0;
        post(1, 1'b0, 32'h0000_0020, 32'h0);
        drive();
        round(0);

        // address changed after sampling: access must use 0x04
        scr_xor = 32'h0000_000C;
        post(0, 1'b1, 32'h0000_0004, 32'hA5A5_0004);
        drive();
        round(0);
        post(1, 1'b0, 32'h0000_0004, 32'h0);
        drive();
        round(0);
        chk("latch_rdata", rdata, 32'hA5A5_0004);
        post(1, 1'b0, 32'h0000_0008, 32'h0);
        drive();
        round(0);

        // misaligned address: error path with the check, word 0 without it
        post(0, 1'b1, 32'h0000_0082, 32'hCAFE_F00D);
        drive();
        round(0);
        post(1, 1'b0, 32'h0000_0000, 32'h0);
        drive();
        round(0);

        for (int i = 0; i < 300; i++) begin
            for (int p = 0; p < 2; p++)
                if (!pend[p] && $urandom_range(0, 2) != 0)
                    post(p, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
            scr_xor = $urandom;
            drive();
            round(0);
        end
        for (int k = 0; k < 2; k++) round(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
